// File: rtl/sync_debounce_edge_pkg.sv
// Shared types and constants for the multi-channel debounce / edge detector.
package sync_pkg;

    typedef enum logic {
        DEB_STABLE,
        DEB_QUALIFY
    } deb_state_e;

    localparam int unsigned GLITCH_CNT_W = 16;

    // Qualification counter width; a single bit is kept even when one sample suffices.
    function automatic int unsigned cnt_w(input int unsigned stable_cycles);
        int unsigned w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_debounce_edge_if.sv
// Bus between control logic (master) and the debouncer (slave).
// SYNC_DEBOUNCE_GLITCH_CNT_EN adds the glitch_cnt status signal.
interface sync_debounce_edge_if #(
    parameter int unsigned DATA_WIDTH = 4
);

    logic                  clr;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] level;
    logic [DATA_WIDTH-1:0] rise;
    logic [DATA_WIDTH-1:0] fall;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [sync_pkg::GLITCH_CNT_W-1:0] glitch_cnt;

    modport master (output clr, in_sync, input level, rise, fall, glitch_cnt);
    modport slave  (input clr, in_sync, output level, rise, fall, glitch_cnt);
`else
    modport master (output clr, in_sync, input level, rise, fall);
    modport slave  (input clr, in_sync, output level, rise, fall);
`endif

endinterface

// File: rtl/sync_debounce_edge_debounce_bit.sv
// Single-channel debouncer: stability qualification, held level and one-cycle
// rise/fall pulses, plus a combinational strobe when a glitch is rejected.
module debounce_bit
    import sync_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter bit          RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic glitch_c
);

    localparam int unsigned CNT_W = cnt_w(STABLE_CYCLES);

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             flip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DEB_STABLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state; clr aborts any qualification, including one completing now.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flip     = 1'b0;
        glitch_c = 1'b0;

        if (clr_i) begin
            state_d = DEB_STABLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DEB_STABLE: begin
                    cnt_d = '0;
                    if (in_i != level_q) begin
                        if (STABLE_CYCLES == 1) begin
                            flip = 1'b1;
                        end else begin
                            state_d = DEB_QUALIFY;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEB_QUALIFY: begin
                    if (in_i == level_q) begin
                        state_d  = DEB_STABLE;
                        cnt_d    = '0;
                        glitch_c = 1'b1;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = DEB_STABLE;
                        cnt_d   = '0;
                        flip    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = DEB_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        level_d = flip ? ~level_q : level_q;
        rise_d  = flip & ~level_q;
        fall_d  = flip &  level_q;
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sync_debounce_edge.sv
// Multi-channel debouncer with rise/fall pulse outputs, one debounce_bit per channel.
// SYNC_DEBOUNCE_GLITCH_CNT_EN adds a saturating count of rejected glitches.
module sync_debounce_edge
    import sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned STABLE_CYCLES = 8,
    parameter bit          RESET_LEVEL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    sync_debounce_edge_if.slave  bus
);

    logic [DATA_WIDTH-1:0] level_v;
    logic [DATA_WIDTH-1:0] rise_v;
    logic [DATA_WIDTH-1:0] fall_v;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [DATA_WIDTH-1:0] glitch_v;
`endif

    for (genvar g = 0; g < int'(DATA_WIDTH); g++) begin : g_chan
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_LEVEL   (RESET_LEVEL)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (bus.clr),
            .in_i     (bus.in_sync[g]),
            .level_o  (level_v[g]),
            .rise_o   (rise_v[g]),
            .fall_o   (fall_v[g]),
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
            .glitch_c (glitch_v[g])
`else
            .glitch_c ()
`endif
        );
    end

    assign bus.level = level_v;
    assign bus.rise  = rise_v;
    assign bus.fall  = fall_v;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    localparam int unsigned POP_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned SUM_W = GLITCH_CNT_W + 1;

    logic [POP_W-1:0]        pop_c;
    logic [SUM_W-1:0]        sum_c;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

    // Popcount of channels rejecting a glitch this cycle, added with saturation.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            pop_c = pop_c + POP_W'(glitch_v[i]);
        end
        sum_c = SUM_W'(glitch_cnt_q) + SUM_W'(pop_c);
        if (bus.clr) begin
            glitch_cnt_d = '0;
        end else if (sum_c[SUM_W-1]) begin
            glitch_cnt_d = '1;
        end else begin
            glitch_cnt_d = sum_c[GLITCH_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign bus.glitch_cnt = glitch_cnt_q;
`endif

endmodule
